// File: rtl/d_latch.sv
// d_latch: level-sensitive D latch, transparent on clk high, async active-low reset, complementary outputs
module d_latch #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  // reset dominates; otherwise open while clk is high and hold while it is low
  always_latch
    if (!rst) q <= RESET_VALUE;
    else if (clk) q <= d;
  assign qbar = ~q;
endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: randomized and directed checks of d_latch against a behavioural model, including a master/slave cascade
module tb_d_latch;
  int checks = 0;
  int errors = 0;
  logic d1, c1, r1, q1, qb1, m1;
  logic [7:0] d8, q8, qb8;
  logic c8, r8;
  logic dc, cc, rc, qa, qab, qc, qcb, ncc, fm, prevc;
  bit cas_on = 0;
  event chk;

  assign ncc = ~cc;

  d_latch u1 (.d(d1), .clk(c1), .rst(r1), .q(q1), .qbar(qb1));
  d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (.d(d8), .clk(c8), .rst(r8), .q(q8), .qbar(qb8));
  d_latch ua (.d(dc), .clk(cc), .rst(rc), .q(qa), .qbar(qab));
  d_latch ub (.d(qa), .clk(ncc), .rst(rc), .q(qc), .qbar(qcb));

  function automatic void cmp(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endfunction

  // model q is the d last seen while open, forced to the reset value while rst is low
  task automatic drive(input logic r, input logic c, input logic dv);
    r1 = r;
    c1 = c;
    d1 = dv;
    m1 = !r ? 1'b0 : (c ? dv : m1);
    #1;
    ->chk;
    #1;
  endtask

  always @(chk) begin
    cmp("model_q", {7'b0, q1}, {7'b0, m1});
    cmp("model_qbar", {7'b0, qb1}, {7'b0, ~m1});
    if (cas_on) begin
      cmp("cascade_q", {7'b0, qc}, {7'b0, fm});
      cmp("cascade_qbar", {7'b0, qcb}, {7'b0, ~fm});
      cmp("master_qbar", {7'b0, qab}, {7'b0, ~qa});
    end
  end

  initial begin
    d8 = 8'h00; c8 = 1'b0; r8 = 1'b0;
    dc = 1'b0; cc = 1'b1; rc = 1'b0; fm = 1'b0; prevc = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'(i & 1), 1'($urandom));
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    cmp("rst_immediate", {7'b0, q1}, 8'h00);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    cmp("transp_rise", {7'b0, q1}, 8'h01);
    drive(1'b1, 1'b1, 1'b0);
    cmp("transp_fall", {7'b0, q1}, 8'h00);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'(i & 1));
    cmp("hold_q", {7'b0, q1}, 8'h01);
    cmp("hold_qbar", {7'b0, qb1}, 8'h00);
    drive(1'b1, 1'b1, 1'b0);
    cmp("hold_reopen", {7'b0, q1}, 8'h00);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    cmp("release_clk0", {7'b0, q1}, 8'h00);
    drive(1'b1, 1'b1, 1'b1);
    cmp("release_then_open", {7'b0, q1}, 8'h01);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    cmp("release_clk1", {7'b0, q1}, 8'h01);
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
    d8 = 8'($urandom);
    #1;
    cmp("w8_rst_q", q8, 8'hA5);
    cmp("w8_rst_qbar", qb8, 8'h5A);
    r8 = 1'b1; c8 = 1'b1; d8 = 8'h3C;
    #1;
    cmp("w8_open", q8, 8'h3C);
    c8 = 1'b0;
    #1;
    d8 = 8'hFF;
    #1;
    cmp("w8_hold_q", q8, 8'h3C);
    cmp("w8_hold_qbar", qb8, 8'hC3);
    cas_on = 1;
    for (int t = 0; t < 120; t++) begin
      cc = (t % 20) < 10;
      rc = t >= 7;
      if (t % 2 == 1) dc = 1'($urandom);
      if (!rc) fm = 1'b0;
      else if (prevc && !cc) fm = dc;
      prevc = cc;
      #1;
      ->chk;
      #1;
    end
    cas_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
